// File: rtl/dilithium_frame_pkg.sv
// rtl/dilithium_frame_pkg.sv - mode/state types and frame length table for the output framer
package dilithium_frame_pkg;

    typedef enum logic [1:0] {
        MODE_KEYGEN = 2'd0,
        MODE_VERIFY = 2'd1,
        MODE_SIGN   = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DONE
    } state_t;

    localparam int CNT_W = 12;

    localparam logic [CNT_W-1:0] LEN_KEYGEN_L2 = 12'd480;
    localparam logic [CNT_W-1:0] LEN_KEYGEN_L3 = 12'd744;
    localparam logic [CNT_W-1:0] LEN_KEYGEN_L5 = 12'd932;
    localparam logic [CNT_W-1:0] LEN_SIGN_L2   = 12'd303;
    localparam logic [CNT_W-1:0] LEN_SIGN_L3   = 12'd412;
    localparam logic [CNT_W-1:0] LEN_SIGN_L5   = 12'd575;
    localparam logic [CNT_W-1:0] LEN_VERIFY_L2 = 12'd1;
    localparam logic [CNT_W-1:0] LEN_VERIFY_L3 = 12'd1;
    localparam logic [CNT_W-1:0] LEN_VERIFY_L5 = 12'd1;

    typedef struct packed {
        logic             legal;
        logic [CNT_W-1:0] len;
    } frame_cfg_t;

    // A zero length doubles as the illegal-configuration marker.
    function automatic frame_cfg_t frame_len(input logic [1:0] mode, input logic [2:0] lvl);
        frame_cfg_t       cfg;
        logic [CNT_W-1:0] l2, l3, l5;
        cfg = '0;
        case (mode)
            MODE_KEYGEN: begin l2 = LEN_KEYGEN_L2; l3 = LEN_KEYGEN_L3; l5 = LEN_KEYGEN_L5; end
            MODE_SIGN:   begin l2 = LEN_SIGN_L2;   l3 = LEN_SIGN_L3;   l5 = LEN_SIGN_L5;   end
            MODE_VERIFY: begin l2 = LEN_VERIFY_L2; l3 = LEN_VERIFY_L3; l5 = LEN_VERIFY_L5; end
            default:     begin l2 = '0;            l3 = '0;            l5 = '0;            end
        endcase
        case (lvl)
            3'd2:    cfg.len = l2;
            3'd3:    cfg.len = l3;
            3'd5:    cfg.len = l5;
            default: cfg.len = '0;
        endcase
        cfg.legal = (cfg.len != '0);
        return cfg;
    endfunction

endpackage

// File: rtl/dilithium_frame_fifo.sv
// rtl/dilithium_frame_fifo.sv - synchronous FIFO with full/empty flags and synchronous clear
module dilithium_frame_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en && !full) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en && !full) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en && !empty) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/dilithium_out_framer.sv
// rtl/dilithium_out_framer.sv - frames/narrows core words to OUT_W beats; xsum port under DILITHIUM_FRAMER_XSUM_EN
module dilithium_out_framer
    import dilithium_frame_pkg::*;
#(
    parameter int IN_W       = 64,
    parameter int OUT_W      = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [2:0]       sec_lvl,
    input  logic             core_valid,
    output logic             core_ready,
    input  logic [IN_W-1:0]  core_data,
    input  logic             sign_reject,
    output logic             valid_o,
    input  logic             ready_o,
    output logic [OUT_W-1:0] data_o,
    output logic             last,
    output logic             done,
    output logic             cfg_err
`ifdef DILITHIUM_FRAMER_XSUM_EN
   ,output logic [OUT_W-1:0] xsum
`endif
);
    localparam int RATIO = IN_W / OUT_W;
    localparam int SW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [SW-1:0] SLICE_LAST = SW'(RATIO - 1);

    state_t           state_q;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] len_q, beats_q, words_q, beat_q;
    logic             rej_q, cfg_err_q, out_valid_q;
    logic [IN_W-1:0]  out_word_q;
    logic [SW-1:0]    slice_q;

    frame_cfg_t       cfg;
    logic [IN_W-1:0]  fifo_rd_data;
    logic             fifo_full, fifo_empty, fifo_wr, fifo_rd;
    logic             stream, xfer, word_end, out_free, want_more;
    logic             rej_now, accept, bypass, last_beat;

    assign cfg       = frame_len(mode, sec_lvl);
    assign stream    = (state_q == ST_STREAM);
    assign xfer      = out_valid_q & ready_o;
    assign word_end  = xfer & (slice_q == SLICE_LAST);
    assign out_free  = ~out_valid_q | word_end;
    assign want_more = (words_q < len_q);
    assign rej_now   = stream & (mode_q == MODE_SIGN) & sign_reject & ~rej_q;

    // Past LEN the framer keeps core_ready high so surplus words are swallowed.
    assign core_ready = stream & ~rej_q & (~want_more | ~fifo_full);
    assign accept     = core_valid & core_ready & want_more & ~rej_now;
    assign bypass     = accept & fifo_empty & out_free;
    assign fifo_wr    = accept & ~bypass;
    assign fifo_rd    = stream & out_free & ~fifo_empty;

    // After a reject the frame ends with whatever is already buffered.
    assign last_beat  = rej_q ? ((slice_q == SLICE_LAST) & fifo_empty)
                              : (beat_q == beats_q - 1'b1);

    assign valid_o = out_valid_q;
    assign data_o  = out_word_q[OUT_W-1:0];
    assign last    = out_valid_q & last_beat;
    assign done    = (state_q == ST_DONE);
    assign cfg_err = cfg_err_q;

    dilithium_frame_fifo #(
        .WIDTH (IN_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr     (done),
        .wr_en   (fifo_wr),
        .wr_data (core_data),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

`ifdef DILITHIUM_FRAMER_XSUM_EN
    logic [OUT_W-1:0] xsum_q;
    assign xsum = xsum_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= '0;
            len_q       <= '0;
            beats_q     <= '0;
            words_q     <= '0;
            beat_q      <= '0;
            rej_q       <= 1'b0;
            cfg_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            slice_q     <= '0;
`ifdef DILITHIUM_FRAMER_XSUM_EN
            xsum_q      <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mode_q  <= mode;
                        words_q <= '0;
                        beat_q  <= '0;
                        rej_q   <= 1'b0;
`ifdef DILITHIUM_FRAMER_XSUM_EN
                        xsum_q  <= '0;
`endif
                        if (cfg.legal) begin
                            len_q     <= cfg.len;
                            beats_q   <= CNT_W'(cfg.len * RATIO);
                            cfg_err_q <= 1'b0;
                            state_q   <= ST_STREAM;
                        end else begin
                            len_q     <= '0;
                            beats_q   <= '0;
                            cfg_err_q <= 1'b1;
                            state_q   <= ST_DONE;
                        end
                    end
                end
                ST_STREAM: begin
                    if (accept) words_q <= words_q + 1'b1;
                    if (xfer) beat_q <= beat_q + 1'b1;
`ifdef DILITHIUM_FRAMER_XSUM_EN
                    if (xfer) xsum_q <= xsum_q ^ out_word_q[OUT_W-1:0];
`endif
                    if (fifo_rd) begin
                        out_word_q  <= fifo_rd_data;
                        out_valid_q <= 1'b1;
                        slice_q     <= '0;
                    end else if (bypass) begin
                        out_word_q  <= core_data;
                        out_valid_q <= 1'b1;
                        slice_q     <= '0;
                    end else if (word_end) begin
                        out_word_q  <= '0;
                        out_valid_q <= 1'b0;
                        slice_q     <= '0;
                    end else if (xfer) begin
                        out_word_q  <= out_word_q >> OUT_W;
                        slice_q     <= slice_q + 1'b1;
                    end
                    if (xfer && last_beat) begin
                        state_q <= ST_DONE;
                    end else if (rej_now && fifo_empty && !out_valid_q) begin
                        state_q <= ST_DONE;
                    end else if (rej_now) begin
                        rej_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    out_valid_q <= 1'b0;
                    out_word_q  <= '0;
                    slice_q     <= '0;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
